// File: rtl/seq_signed_divider.sv
// Sequential signed divider: sign-magnitude restoring shift-subtract, one quotient bit per clock.
// Quotient truncates toward zero, remainder follows the dividend's sign; dz/ovf flag the corner cases.
module seq_signed_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         dz,
  output logic         ovf
);
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;
  state_t state, state_nx;

  logic [W-1:0]  quo, rem, dvs, xa, ya;
  logic [W:0]    trial;
  logic [CW-1:0] cnt;
  logic          sx, sy, ovf_p, zdiv, last;

  // Two's-complement magnitudes: -2^(W-1) maps to 2^(W-1), still representable unsigned.
  assign xa    = X[W-1] ? (~X + ONE) : X;
  assign ya    = Y[W-1] ? (~Y + ONE) : Y;
  assign zdiv  = (Y == '0);
  assign last  = (cnt == CW'(W - 1));
  assign trial = {rem, quo[W-1]} - {1'b0, dvs};
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !zdiv) state_nx = CALC;
      CALC:    if (last) state_nx = SIGN;
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo <= '0; rem <= '0; dvs <= '0; cnt <= '0;
      sx <= 1'b0; sy <= 1'b0; ovf_p <= 1'b0;
      done <= 1'b0; Q <= '0; R <= '0; dz <= 1'b0; ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (zdiv) begin
            Q <= '1; R <= X; dz <= 1'b1; ovf <= 1'b0; done <= 1'b1;
          end else begin
            quo   <= xa;
            rem   <= '0;
            dvs   <= ya;
            sx    <= X[W-1];
            sy    <= Y[W-1];
            cnt   <= '0;
            ovf_p <= (X == MINV) && (Y == '1);
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          // rem < dvs <= 2^(W-1) keeps rem's MSB clear, so the restore shift loses nothing.
          if (!trial[W]) begin
            rem <= trial[W-1:0];
            quo <= {quo[W-2:0], 1'b1};
          end else begin
            rem <= {rem[W-2:0], quo[W-1]};
            quo <= {quo[W-2:0], 1'b0};
          end
        end
        SIGN: begin
          Q    <= (sx ^ sy) ? (~quo + ONE) : quo;
          R    <= sx ? (~rem + ONE) : rem;
          dz   <= 1'b0;
          ovf  <= ovf_p;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: directed table, handshake/reset sequences, random ops and
// an exhaustive W=8 sweep spread over parallel instances, all against an integer-arithmetic model.
module tb_seq_signed_divider;
  localparam int W   = 8;
  localparam int NL  = 32;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst, srst, start, busy, done, dz, ovf;
  logic [W-1:0] X, Y, Q, R;
  int checks = 0, errors = 0, lanes_fin = 0;

  always #5 clk = ~clk;

  seq_signed_divider #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .Q(Q), .R(R), .dz(dz), .ovf(ovf)
  );

  // Reference: {Q, R, dz, ovf} from plain integer division (truncates toward zero).
  function automatic logic [2*W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int xi, yi, q, r;
    xi = int'($signed(x));
    yi = int'($signed(y));
    if (yi == 0) return {8'hFF, x, 1'b1, 1'b0};
    if (xi == -128 && yi == -1) return {8'h80, 8'h00, 1'b0, 1'b1};
    q = xi / yi;
    r = xi % yi;
    return {q[W-1:0], r[W-1:0], 1'b0, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Issue one op; lat = edges from accepting edge to the edge that raised done.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [2*W+1:0] res, output int lat);
    @(negedge clk);
    start = 1'b1; X = x; Y = y;
    @(posedge clk); #1;
    start = 1'b0; X = 8'($urandom); Y = 8'($urandom);
    lat = 0;
    while (!done && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {Q, R, dz, ovf};
  endtask

  typedef struct {
    logic [W-1:0] x, y, q, r;
    logic         dz, ovf;
  } vec_t;
  vec_t tbl[11];

  initial begin
    logic [2*W+1:0] res, exp;
    int lat, nd, dedge, cyc;
    logic [W-1:0] rx, ry;

    tbl[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0};
    tbl[1]  = '{8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0, 1'b0};
    tbl[2]  = '{8'd100, 8'hF9,  8'hF2,  8'd2,   1'b0, 1'b0};
    tbl[3]  = '{8'h9C,  8'hF9,  8'd14,  8'hFE,  1'b0, 1'b0};
    tbl[4]  = '{8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1};
    tbl[5]  = '{8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0};
    tbl[6]  = '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1'b0};
    tbl[7]  = '{8'd15,  8'd4,   8'd3,   8'd3,   1'b0, 1'b0};
    tbl[8]  = '{8'h7F,  8'h80,  8'd0,   8'h7F,  1'b0, 1'b0};
    tbl[9]  = '{8'h80,  8'h80,  8'd1,   8'd0,   1'b0, 1'b0};
    tbl[10] = '{8'h80,  8'd0,   8'hFF,  8'h80,  1'b1, 1'b0};

    rst = 1'b1; srst = 1'b1; start = 1'b0; X = '0; Y = '0;
    #1 chk("reset_async", {busy, done, Q, R, dz, ovf}, '0);
    repeat (2) @(posedge clk);
    #1 chk("reset_held", {busy, done, Q, R, dz, ovf}, '0);
    @(negedge clk); rst = 1'b0; srst = 1'b0;

    // Latency and busy window for 100/7.
    @(negedge clk); start = 1'b1; X = 8'd100; Y = 8'd7;
    @(posedge clk); #1; start = 1'b0; X = 8'($urandom); Y = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("busy_e%0d", i), {busy, done}, 2'b10);
    end
    @(posedge clk); #1;
    chk("done_e9", {busy, done, Q, R, dz, ovf}, {1'b0, 1'b1, 8'd14, 8'd2, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("done_pulse", {done, Q, R}, {1'b0, 8'd14, 8'd2});

    // Directed table, issued back to back.
    foreach (tbl[i]) begin
      run_op(tbl[i].x, tbl[i].y, res, lat);
      chk($sformatf("tbl%0d", i), res, {tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf});
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].dz ? 0 : 9);
    end

    // start held high through the whole busy period.
    @(negedge clk); start = 1'b1; X = 8'd100; Y = 8'd7;
    @(posedge clk); #1; X = 8'd3; Y = 8'd1;
    nd = 0; dedge = 0;
    for (int i = 1; i <= 22; i++) begin
      @(posedge clk); #1;
      if (i == 8) start = 1'b0;
      if (done) begin
        nd++;
        if (nd == 1) begin dedge = i; rx = Q; ry = R; end
      end
    end
    chk("hold_start_ndone", nd, 1);
    chk("hold_start_edge", dedge, 9);
    chk("hold_start_qr", {rx, ry}, {8'd14, 8'd2});

    // Reset mid-division.
    @(negedge clk); start = 1'b1; X = 8'd100; Y = 8'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); rst = 1'b1;
    #1 chk("rst_mid", {busy, done, Q, R, dz, ovf}, '0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("rst_no_done", nd, 0);
    run_op(8'd15, 8'd4, res, lat);
    chk("post_rst", {res, 8'(lat)}, {8'd3, 8'd3, 1'b0, 1'b0, 8'd9});

    // Random ops with random gaps and occasional zero divisor.
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rx = 8'($urandom);
      ry = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      exp = model(rx, ry);
      run_op(rx, ry, res, lat);
      chk($sformatf("rnd x=%0d y=%0d", $signed(rx), $signed(ry)), res, exp);
      chk("rnd_lat", lat, (ry == 0) ? 0 : 9);
    end

    cyc = 0;
    while (lanes_fin < NL && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    chk("sweep_lanes_fin", lanes_fin, NL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Exhaustive sweep: lane g handles dividends g, g+NL, ... against all 256 divisors.
  for (genvar g = 0; g < NL; g++) begin : lane
    logic s_start, s_busy, s_done, s_dz, s_ovf;
    logic [W-1:0] s_x, s_y, s_q, s_r;

    seq_signed_divider #(.W(W)) u_div (
      .clk(clk), .rst(srst), .start(s_start), .X(s_x), .Y(s_y),
      .busy(s_busy), .done(s_done), .Q(s_q), .R(s_r), .dz(s_dz), .ovf(s_ovf)
    );

    initial begin
      int t;
      logic [2*W+1:0] e;
      s_start = 1'b0; s_x = '0; s_y = '0;
      do @(negedge clk); while (srst !== 1'b0);
      for (int k = 0; k < 256 / NL; k++) begin
        for (int y = 0; y < 256; y++) begin
          @(negedge clk);
          s_start = 1'b1; s_x = W'(g + NL * k); s_y = W'(y);
          @(posedge clk); #1;
          s_start = 1'b0;
          t = 0;
          while (!s_done && t < TMO) begin
            @(posedge clk); #1;
            t++;
          end
          e = model(s_x, s_y);
          checks++;
          if (t >= TMO || {s_q, s_r, s_dz, s_ovf} !== e) begin
            errors++;
            $display("FAIL sweep x=%0d y=%0d got=%h exp=%h t=%0d",
                     $signed(s_x), $signed(s_y), {s_q, s_r, s_dz, s_ovf}, e, t);
          end
        end
      end
      lanes_fin++;
    end
  end
endmodule

// File: doc/seq_signed_divider.md
SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 SHALL have parameter W, default 8, meaning the operand, quotient and remainder width in bits (W >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled on the rising edge of clk.
REQ-005 SHALL have port X, input, W, signed dividend.
REQ-006 SHALL have port Y, input, W, signed divisor.
REQ-007 SHALL have port busy, output, 1, high while a division is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-009 SHALL have port Q, output, W, signed quotient (registered).
REQ-010 SHALL have port R, output, W, signed remainder (registered).
REQ-011 SHALL have port dz, output, 1, divide-by-zero flag for the last completed operation.
REQ-012 SHALL have port ovf, output, 1, overflow flag for the last completed operation.

Function
REQ-013 SHALL implement states IDLE, CALC, SIGN; busy = (state != IDLE).
REQ-014 In IDLE with start=1 at edge N and Y != 0: latch |X|, |Y|, sign(X), sign(Y) as W-bit unsigned magnitudes; clear the iteration counter; go to CALC.
REQ-015 CALC SHALL perform one restoring shift-subtract step per edge, for exactly W edges (N+1..N+W), then go to SIGN.
REQ-016 At edge N+W+1 in SIGN: register Q and R, registered done=1 for one cycle, busy=0, state IDLE. Latency is start edge to done W+1 edges (9 for W=8).
REQ-017 Quotient SHALL truncate toward zero; Q negated iff sign(X) != sign(Y); R has the sign of X (or is zero); |R| < |Y|; X = Q*Y + R.
REQ-018 The unsigned magnitude of the most-negative value (-2^(W-1)) SHALL be 2^(W-1), without loss.
REQ-019 X = -2^(W-1) and Y = -1 SHALL give Q = -2^(W-1) (the wrapped result), R = 0, ovf = 1.
REQ-020 ovf SHALL be 0 for every other operand pair.
REQ-021 Start with Y = 0 in IDLE SHALL skip CALC: at edge N, Q = all ones, R = X, dz = 1, ovf = 0, done = 1 for one cycle, state stays IDLE.
REQ-022 dz SHALL be 0 for every nonzero divisor.
REQ-023 start SHALL be ignored while busy = 1; the operation in flight completes unchanged.
REQ-024 X and Y SHALL be don't-care except at the accepting edge.
REQ-025 Start asserted in the same cycle as done (state IDLE) SHALL be accepted normally (back-to-back operation).
REQ-026 Q, R, dz and ovf SHALL hold their values until the next done.
REQ-027 Q, R, dz and ovf SHALL update only on the edge that asserts done.
REQ-028 done SHALL never be high for two consecutive cycles.

Reset
REQ-029 rst=1 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, Q=0, R=0, dz=0, ovf=0, and clear the iteration counter and internal registers.
REQ-030 rst asserted mid-operation SHALL abort the division; no done is produced for it.
REQ-031 The first start accepted after rst deasserts SHALL behave as from power-up.

Verification
REQ-032 Directed test: X=100, Y=7, start at edge N -> done at edge N+9; Q=14, R=2, dz=0, ovf=0; busy high for edges N+1..N+8.
REQ-033 Directed test, signs: X=-100, Y=7 -> Q=-14, R=-2; X=100, Y=-7 -> Q=-14, R=2; X=-100, Y=-7 -> Q=14, R=-2.
REQ-034 Directed test, edges: X=-128, Y=-1 -> Q=-128 (8'h80), R=0, ovf=1; X=-128, Y=1 -> Q=-128, ovf=0; X=5, Y=0 -> done at edge N, Q=8'hFF, R=5, dz=1.
REQ-035 Directed test, handshake: start re-asserted every cycle during a busy period -> exactly one done per accepted operation; start in the done cycle -> next done 9 edges later.
REQ-036 Directed test, reset: rst asserted at edge N+4 of a division -> all outputs 0 immediately; no done follows; a new X=15, Y=4 op then gives Q=3, R=3.
REQ-037 The bench SHALL compare Q and R against truncating signed division for an exhaustive sweep of all 65536 (X, Y) pairs at W=8.
